// File: rtl/control_sequencer.sv
// Micro-step sequencer for a small accumulator CPU: walks fetch steps T0/T1, then 1-3
// execute steps chosen by the opcode, and parks in HALT until reset.
module control_sequencer #(
   parameter int ADDR_W = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] opcode,
   input  logic       flag_zero,
   input  logic       flag_carry,
   output logic [2:0] step,
   output logic       halted,
   output logic [2:0] bus_sel,
   output logic       load_mar,
   output logic       load_ir,
   output logic       load_a,
   output logic       load_b,
   output logic       load_o,
   output logic       load_flags,
   output logic       ram_we,
   output logic       pc_inc,
   output logic       pc_load,
   output logic       alu_sub
);

   typedef enum logic [2:0] {
      FETCH_T0,
      FETCH_T1,
      EXEC_T2,
      EXEC_T3,
      EXEC_T4,
      HALT
   } state_t;

   // The operand field width belongs to the surrounding datapath; a zero width is meaningless.
   localparam logic AddrWidthOk = (ADDR_W > 0);

   localparam logic [2:0] BUS_NONE = 3'd0;
   localparam logic [2:0] BUS_PC   = 3'd1;
   localparam logic [2:0] BUS_RAM  = 3'd2;
   localparam logic [2:0] BUS_OPND = 3'd3;
   localparam logic [2:0] BUS_A    = 3'd4;
   localparam logic [2:0] BUS_ALU  = 3'd5;

   localparam logic [3:0] OP_LDA = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_STA = 4'h4;
   localparam logic [3:0] OP_LDI = 4'h5;
   localparam logic [3:0] OP_JMP = 4'h6;
   localparam logic [3:0] OP_JC  = 4'h7;
   localparam logic [3:0] OP_JZ  = 4'h8;
   localparam logic [3:0] OP_OUT = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   state_t r_state;
   state_t w_next;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= FETCH_T0;
      else       r_state <= w_next;
   end

   // Outputs are held at zero for as long as reset is high, independent of the clock,
   // so an abandoned instruction can never leak a strobe once reset rises.
   always_comb begin
      w_next     = r_state;
      step       = 3'd0;
      halted     = 1'b0;
      bus_sel    = BUS_NONE;
      load_mar   = 1'b0;
      load_ir    = 1'b0;
      load_a     = 1'b0;
      load_b     = 1'b0;
      load_o     = 1'b0;
      load_flags = 1'b0;
      ram_we     = 1'b0;
      pc_inc     = 1'b0;
      pc_load    = 1'b0;
      alu_sub    = 1'b0;
      if (!reset && AddrWidthOk) begin
         case (r_state)
            FETCH_T0: begin
               step     = 3'd0;
               bus_sel  = BUS_PC;
               load_mar = 1'b1;
               w_next   = FETCH_T1;
            end
            FETCH_T1: begin
               step    = 3'd1;
               bus_sel = BUS_RAM;
               load_ir = 1'b1;
               pc_inc  = 1'b1;
               w_next  = EXEC_T2;
            end
            EXEC_T2: begin
               step   = 3'd2;
               w_next = FETCH_T0;
               case (opcode)
                  OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                     bus_sel  = BUS_OPND;
                     load_mar = 1'b1;
                     w_next   = EXEC_T3;
                  end
                  OP_LDI: begin
                     bus_sel = BUS_OPND;
                     load_a  = 1'b1;
                  end
                  OP_JMP: begin
                     bus_sel = BUS_OPND;
                     pc_load = 1'b1;
                  end
                  OP_JC: begin
                     bus_sel = flag_carry ? BUS_OPND : BUS_NONE;
                     pc_load = flag_carry;
                  end
                  OP_JZ: begin
                     bus_sel = flag_zero ? BUS_OPND : BUS_NONE;
                     pc_load = flag_zero;
                  end
                  OP_OUT: begin
                     bus_sel = BUS_A;
                     load_o  = 1'b1;
                  end
                  OP_HLT:  w_next = HALT;
                  default: w_next = FETCH_T0;
               endcase
            end
            EXEC_T3: begin
               step   = 3'd3;
               w_next = FETCH_T0;
               case (opcode)
                  OP_LDA: begin
                     bus_sel = BUS_RAM;
                     load_a  = 1'b1;
                  end
                  OP_ADD, OP_SUB: begin
                     bus_sel = BUS_RAM;
                     load_b  = 1'b1;
                     w_next  = EXEC_T4;
                  end
                  OP_STA: begin
                     bus_sel = BUS_A;
                     ram_we  = 1'b1;
                  end
                  default: w_next = FETCH_T0;
               endcase
            end
            EXEC_T4: begin
               step   = 3'd4;
               w_next = FETCH_T0;
               if (opcode == OP_ADD || opcode == OP_SUB) begin
                  bus_sel    = BUS_ALU;
                  load_a     = 1'b1;
                  load_flags = 1'b1;
                  alu_sub    = (opcode == OP_SUB);
               end
            end
            HALT: begin
               halted = 1'b1;
               w_next = HALT;
            end
            default: w_next = FETCH_T0;
         endcase
      end
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed instruction table, random
// instruction stream against a micro-program reference model, and reset/halt corners.
module tb_control_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] opcode;
   logic       flag_zero;
   logic       flag_carry;
   logic [2:0] step;
   logic       halted;
   logic [2:0] bus_sel;
   logic       load_mar, load_ir, load_a, load_b, load_o, load_flags;
   logic       ram_we, pc_inc, pc_load, alu_sub;

   control_sequencer #(.ADDR_W(4)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .flag_zero(flag_zero), .flag_carry(flag_carry),
      .step(step), .halted(halted), .bus_sel(bus_sel),
      .load_mar(load_mar), .load_ir(load_ir), .load_a(load_a), .load_b(load_b),
      .load_o(load_o), .load_flags(load_flags), .ram_we(ram_we),
      .pc_inc(pc_inc), .pc_load(pc_load), .alu_sub(alu_sub)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] step;
      logic       halted;
      logic [2:0] bus;
      logic [9:0] strobes;
   } out_t;

   // Strobe order: mar, ir, a, b, o, flags, we, inc, pcload, sub
   localparam logic [9:0] MAR = 10'b1000000000;
   localparam logic [9:0] IR  = 10'b0100000000;
   localparam logic [9:0] LA  = 10'b0010000000;
   localparam logic [9:0] LB  = 10'b0001000000;
   localparam logic [9:0] LO  = 10'b0000100000;
   localparam logic [9:0] FLG = 10'b0000010000;
   localparam logic [9:0] WE  = 10'b0000001000;
   localparam logic [9:0] INC = 10'b0000000100;
   localparam logic [9:0] LD  = 10'b0000000010;
   localparam logic [9:0] SUB = 10'b0000000001;

   typedef struct {
      logic [3:0] op;
      logic       fz;
      logic       fc;
      logic [2:0] t2Bus;
      logic [2:0] lastStep;
   } vec_t;

   int   checks = 0;
   int   errors = 0;
   out_t expQ[$];

   function automatic out_t mk(int st, int bus, logic [9:0] s, logic h);
      out_t r;
      r.step    = 3'(st);
      r.halted  = h;
      r.bus     = 3'(bus);
      r.strobes = s;
      return r;
   endfunction

   function automatic out_t current();
      return {step, halted, bus_sel, load_mar, load_ir, load_a, load_b, load_o,
              load_flags, ram_we, pc_inc, pc_load, alu_sub};
   endfunction

   // Reference: the micro-program of one instruction as a list of per-step outputs.
   task automatic buildExpected(input logic [3:0] op, input logic fz, input logic fc);
      expQ = {};
      expQ.push_back(mk(0, 1, MAR, 1'b0));
      expQ.push_back(mk(1, 2, IR | INC, 1'b0));
      case (op)
         4'h1: begin
            expQ.push_back(mk(2, 3, MAR, 1'b0));
            expQ.push_back(mk(3, 2, LA, 1'b0));
         end
         4'h2, 4'h3: begin
            expQ.push_back(mk(2, 3, MAR, 1'b0));
            expQ.push_back(mk(3, 2, LB, 1'b0));
            expQ.push_back(mk(4, 5, LA | FLG | ((op == 4'h3) ? SUB : 10'd0), 1'b0));
         end
         4'h4: begin
            expQ.push_back(mk(2, 3, MAR, 1'b0));
            expQ.push_back(mk(3, 4, WE, 1'b0));
         end
         4'h5: expQ.push_back(mk(2, 3, LA, 1'b0));
         4'h6: expQ.push_back(mk(2, 3, LD, 1'b0));
         4'h7: expQ.push_back(fc ? mk(2, 3, LD, 1'b0) : mk(2, 0, 10'd0, 1'b0));
         4'h8: expQ.push_back(fz ? mk(2, 3, LD, 1'b0) : mk(2, 0, 10'd0, 1'b0));
         4'hE: expQ.push_back(mk(2, 4, LO, 1'b0));
         default: expQ.push_back(mk(2, 0, 10'd0, 1'b0));
      endcase
   endtask

   task automatic applyStimulus(input logic [3:0] op, input logic fz, input logic fc);
      opcode     = op;
      flag_zero  = fz;
      flag_carry = fc;
   endtask

   task automatic checkOutput(input string name, input out_t exp);
      out_t got;
      got = current();
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got step=%0d halted=%0b bus=%0d strobes=%b, expected step=%0d halted=%0b bus=%0d strobes=%b",
                  name, got.step, got.halted, got.bus, got.strobes,
                  exp.step, exp.halted, exp.bus, exp.strobes);
      end
   endtask

   task automatic checkValue(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // Opcode and flags are scrambled outside T2 so only the T2 values may matter.
   task automatic runInstruction(input logic [3:0] op, input logic fz, input logic fc,
                                 output logic [2:0] t2Bus, output logic [2:0] lastStep);
      buildExpected(op, fz, fc);
      t2Bus    = 3'd7;
      lastStep = 3'd7;
      for (int i = 0; i < expQ.size(); i++) begin
         @(negedge clk);
         if (i < 2)       applyStimulus(4'($urandom), 1'($urandom), 1'($urandom));
         else if (i == 2) applyStimulus(op, fz, fc);
         else             applyStimulus(op, 1'($urandom), 1'($urandom));
         #1;
         checkOutput($sformatf("op%0h_T%0d", op, i), expQ[i]);
         if (i == 2) t2Bus = bus_sel;
         lastStep = step;
      end
      @(posedge clk);
      #1;
      checkOutput($sformatf("op%0h_after", op),
                  (op == 4'hF) ? mk(0, 0, 10'd0, 1'b1) : mk(0, 1, MAR, 1'b0));
   endtask

   vec_t       vecs[13];
   logic [2:0] t2b, ls;
   logic [3:0] rop;

   initial begin
      vecs[0]  = '{op: 4'h1, fz: 1'b0, fc: 1'b0, t2Bus: 3'd3, lastStep: 3'd3};
      vecs[1]  = '{op: 4'h3, fz: 1'b0, fc: 1'b1, t2Bus: 3'd3, lastStep: 3'd4};
      vecs[2]  = '{op: 4'h8, fz: 1'b0, fc: 1'b1, t2Bus: 3'd0, lastStep: 3'd2};
      vecs[3]  = '{op: 4'h8, fz: 1'b1, fc: 1'b0, t2Bus: 3'd3, lastStep: 3'd2};
      vecs[4]  = '{op: 4'hB, fz: 1'b1, fc: 1'b1, t2Bus: 3'd0, lastStep: 3'd2};
      vecs[5]  = '{op: 4'h2, fz: 1'b0, fc: 1'b0, t2Bus: 3'd3, lastStep: 3'd4};
      vecs[6]  = '{op: 4'h4, fz: 1'b0, fc: 1'b0, t2Bus: 3'd3, lastStep: 3'd3};
      vecs[7]  = '{op: 4'h5, fz: 1'b0, fc: 1'b0, t2Bus: 3'd3, lastStep: 3'd2};
      vecs[8]  = '{op: 4'h6, fz: 1'b0, fc: 1'b0, t2Bus: 3'd3, lastStep: 3'd2};
      vecs[9]  = '{op: 4'h7, fz: 1'b1, fc: 1'b0, t2Bus: 3'd0, lastStep: 3'd2};
      vecs[10] = '{op: 4'h7, fz: 1'b0, fc: 1'b1, t2Bus: 3'd3, lastStep: 3'd2};
      vecs[11] = '{op: 4'h0, fz: 1'b1, fc: 1'b1, t2Bus: 3'd0, lastStep: 3'd2};
      vecs[12] = '{op: 4'hE, fz: 1'b0, fc: 1'b0, t2Bus: 3'd4, lastStep: 3'd2};

      reset = 1'b1;
      applyStimulus(4'h1, 1'b0, 1'b0);
      repeat (2) begin
         @(posedge clk);
         #1;
         checkOutput("inReset", mk(0, 0, 10'd0, 1'b0));
      end
      #2 reset = 1'b0;
      #1 checkOutput("releaseT0", mk(0, 1, MAR, 1'b0));

      for (int v = 0; v < 13; v++) begin
         runInstruction(vecs[v].op, vecs[v].fz, vecs[v].fc, t2b, ls);
         checkValue($sformatf("vec%0d_t2Bus", v), int'(t2b), int'(vecs[v].t2Bus));
         checkValue($sformatf("vec%0d_lastStep", v), int'(ls), int'(vecs[v].lastStep));
      end

      for (int n = 0; n < 40; n++) begin
         rop = 4'($urandom_range(0, 14));
         runInstruction(rop, 1'($urandom), 1'($urandom), t2b, ls);
      end

      // Reset arriving in T3 of an ADD must kill load_b at once and restart at T0.
      buildExpected(4'h2, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         applyStimulus(4'h2, 1'b0, 1'b0);
         #1;
         checkOutput($sformatf("abortAdd_T%0d", i), expQ[i]);
      end
      #2 reset = 1'b1;
      #1 checkOutput("abortAdd_asyncZero", mk(0, 0, 10'd0, 1'b0));
      @(posedge clk);
      #1 checkOutput("abortAdd_heldZero", mk(0, 0, 10'd0, 1'b0));
      #2 reset = 1'b0;
      #1 checkOutput("abortAdd_restartT0", mk(0, 1, MAR, 1'b0));
      runInstruction(4'h0, 1'b0, 1'b0, t2b, ls);

      runInstruction(4'hF, 1'b0, 1'b0, t2b, ls);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         applyStimulus(4'($urandom), 1'($urandom), 1'($urandom));
         #1 checkOutput($sformatf("halt_%0d", i), mk(0, 0, 10'd0, 1'b1));
      end
      #2 reset = 1'b1;
      #1 checkOutput("haltResetAsync", mk(0, 0, 10'd0, 1'b0));
      @(posedge clk);
      #3 reset = 1'b0;
      #1 checkOutput("haltReleaseT0", mk(0, 1, MAR, 1'b0));
      runInstruction(4'h1, 1'b0, 1'b0, t2b, ls);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter ADDR_W, default 4, is the width of the operand/address field.
REQ-002 clk  input  1  system clock; all state updates occur on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 opcode  input  4  instruction register upper nibble; valid from step T2 onward.
REQ-005 flag_zero  input  1  registered zero flag from the flags register.
REQ-006 flag_carry  input  1  registered carry flag from the flags register.
REQ-007 step  output  3  current micro-step: 0=T0 .. 4=T4.
REQ-008 halted  output  1  sequencer is in HALT.
REQ-009 bus_sel  output  3  bus source: 0 none, 1 PC, 2 RAM, 3 IR operand, 4 A, 5 ALU.
REQ-010 load_mar, load_ir, load_a, load_b, load_o, load_flags  output  1 each  load strobes to the target n-bit registers.
REQ-011 ram_we, pc_inc, pc_load, alu_sub  output  1 each  RAM write, PC increment, PC load, ALU subtract select.

Function
REQ-012 State SHALL be one register holding FETCH_T0..EXEC_T4 plus HALT; all outputs decode combinationally from state, opcode and flags.
REQ-013 Exactly one bus_sel source SHALL be active per step; unused steps drive bus_sel=0 and every strobe 0.
REQ-014 T0: bus_sel=1, load_mar=1.
REQ-015 T1: bus_sel=2, load_ir=1, pc_inc=1.
REQ-016 T2..T4 SHALL follow opcode; after an instruction's last step the next state SHALL be T0 (variable length: 3 to 5 cycles).
REQ-017 0x0 NOP: T2 no strobes; last step T2.
REQ-018 0x1 LDA: T2 bus_sel=3, load_mar; T3 bus_sel=2, load_a; last T3.
REQ-019 0x2 ADD: T2 bus_sel=3, load_mar; T3 bus_sel=2, load_b; T4 bus_sel=5, load_a, load_flags, alu_sub=0; last T4.
REQ-020 0x3 SUB: as ADD with alu_sub=1 during T4 only.
REQ-021 0x4 STA: T2 bus_sel=3, load_mar; T3 bus_sel=4, ram_we; last T3.
REQ-022 0x5 LDI: T2 bus_sel=3, load_a; last T2.
REQ-023 0x6 JMP: T2 bus_sel=3, pc_load; last T2.
REQ-024 0x7 JC / 0x8 JZ: T2 pc_load with bus_sel=3 only if flag_carry / flag_zero is 1 at T2; otherwise no strobes; last T2 either way.
REQ-025 0xE OUT: T2 bus_sel=4, load_o; last T2.
REQ-026 0xF HLT: T2 no strobes; next state HALT.
REQ-027 Undefined opcodes (0x9-0xD) SHALL execute as NOP.
REQ-028 HALT: halted=1, step=0, all strobes 0, bus_sel=0; exits only via reset.
REQ-029 pc_inc and pc_load SHALL never be asserted in the same cycle.
REQ-030 Opcode changes during T0/T1 SHALL not affect T0/T1 outputs.

Reset
REQ-031 While reset=1: state=T0, step=0, halted=0, bus_sel=0, all strobes 0, regardless of clk.
REQ-032 Reset asserted mid-instruction SHALL abandon it; no strobe of the abandoned step may be asserted after reset rises.
REQ-033 First rising edge after reset release SHALL sample T0 outputs (bus_sel=1, load_mar=1).

Verification
REQ-034 Release reset, opcode=0x1 -> steps 0,1,2,3,0; load_mar at T0 and T2, load_ir+pc_inc at T1, load_a at T3 with bus_sel=2.
REQ-035 opcode=0x3 -> 5-cycle instruction; T4 shows bus_sel=5, load_a=1, load_flags=1, alu_sub=1; alu_sub=0 at all other steps.
REQ-036 opcode=0x8 with flag_zero=0 then 1 -> first instance no pc_load, second pc_load=1 at T2; both return to T0 after T2.
REQ-037 opcode=0xF -> halted=1 from cycle after T2; 20 further clocks keep halted=1, all strobes 0; reset clears halted asynchronously.
REQ-038 Assert reset during T3 of ADD -> outputs zero immediately; after release sequence restarts at T0, no load_b/load_a from the aborted ADD.
REQ-039 opcode=0xB -> behaves as NOP: 3 cycles, no strobes at T2.
